odd_clk_divider: RTL and testbench
==================================

// Module: odd_clk_divider
// PURPOSE
//  Programmable clock divider that generates the divided clock clk_odd consumed by the PWM stage.
//  Duty cycle is 50% for both odd and even divisors. Odd divisors use a negedge-stretched phase.
//  The divisor can be changed at runtime through a load/ack handshake.
//  Changes take effect only at a period boundary, so clk_odd never glitches.
//  Emits a one-cycle tick per divided period for downstream counters.
// PARAMETERS
//  DIV_WIDTH    8  width of divisor and phase counter
//  DEFAULT_DIV  5  divisor active after reset; must be in 2..2^DIV_WIDTH-1
// PORTS
//  clk         in   1          source clock
//  rst_n       in   1          asynchronous active-low reset
//  en          in   1          1 = divide, 0 = hold idle (clk_odd low)
//  div_in      in   DIV_WIDTH  requested divisor N
//  div_load    in   1          1-cycle strobe: capture div_in
//  div_ack     out  1          1-cycle pulse: pending divisor applied
//  div_err     out  1          1-cycle pulse: div_in rejected (N<2)
//  div_active  out  DIV_WIDTH  divisor currently in use
//  tick        out  1          1-cycle pulse, high during the cycle where cnt==0
//  clk_odd     out  1          divided clock, 50% duty
// BEHAVIOUR
//  - Reset (async, immediate): cnt=0, pos_q=0, neg_q=0, pend_vld=0, div_active=DEFAULT_DIV.
//    div_ack, div_err, tick and clk_odd are all 0.
//  - Phase counter cnt counts 0..N-1 on posedge clk while en=1, then wraps to 0.
//  - H = ceil(N/2). pos_q (posedge flop) is 1 exactly during the cycles where cnt < H.
//  - neg_q is pos_q re-sampled on negedge clk; it is also cleared async by rst_n.
//  - clk_odd = N odd ? (pos_q & neg_q) : pos_q.
//    Odd N: high for (N-1)/2 + 0.5 clk periods, from the negedge of cycle 0 to the posedge ending cycle H-1.
//    Even N: high for N/2 periods starting at cycle 0.
//    Odd/even select uses div_active[0] registered alongside pos_q, so the select is glitch-free.
//  - tick=1 for the single cycle in which cnt==0 and en=1. Period is N cycles.
//  - Load handshake, div_load=1 at edge k:
//    . div_in<2: div_err=1 during cycle k+1. Pending state and div_active are unchanged.
//    . div_in>=2: value stored in pending register, pend_vld=1.
//    . While pend_vld=1, a further legal load overwrites pending (last wins); only one ack is issued.
//  - Apply rule: at the posedge where cnt==N-1 (wrap) with pend_vld=1:
//    div_active <= pending and pend_vld <= 0. div_ack=1 for the following cycle, i.e. the first cycle of the new period.
//    A load on the same edge as the wrap is captured but applied at the next wrap.
//    Exception: the wrap edge already carrying an existing pending value applies that older value.
//  - en=0 (sampled at posedge): cnt<=0 and pos_q<=0. clk_odd falls no later than the next negedge.
//    tick=0 while disabled.
//    While en=0, a pending value is applied on the next posedge and acked the cycle after.
//  - en 0->1: the first enabled cycle is cnt=0 with tick=1. The first high phase has full length.
//  - div_active is only written at a wrap or while idle. cnt never exceeds div_active-1.
//  - No combinational path from any input to clk_odd. clk_odd is derived only from the pos_q/neg_q flops.
// TESTING
//  1. Reset release, en=1, DEFAULT_DIV=5 -> clk_odd high 2.5 clk, low 2.5 clk, period 5. tick every 5 cycles.
//  2. Mid-period div_load with div_in=4 -> div_ack 1 cycle after the next wrap; div_active=4.
//     Following periods are 2 high, 2 low. No runt pulse at the switch.
//  3. div_load with div_in=1, then div_in=0 -> div_err pulses one cycle after each.
//     div_active stays 5; div_ack never asserts.
//  4. div_load 7, then div_load 9 before the wrap -> single div_ack; div_active=9.
//     Period 9, high 4.5 clk.
//  5. en=0 during a high phase -> clk_odd low within one clk, tick stops.
//     Re-enable -> tick on the first cycle, then a full-length high phase.
//  6. rst_n asserted mid high phase on a negedge -> clk_odd=0 immediately, all outputs at reset values.
//     Release -> restarts with N=5.

Source files
------------

// File: rtl/odd_clk_divider.sv
// rtl/odd_clk_divider.sv - programmable 50% duty clock divider with glitch-free divisor reload
module odd_clk_divider #(
    parameter int DIV_WIDTH   = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 div_load,
    output logic                 div_ack,
    output logic                 div_err,
    output logic [DIV_WIDTH-1:0] div_active,
    output logic                 tick,
    output logic                 clk_odd
);

    localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE     = DIV_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] TWO     = DIV_WIDTH'(2);
    localparam logic [DIV_WIDTH:0]   ONE_W   = (DIV_WIDTH+1)'(1);

    // Phase counter and divisor state
    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] cnt_nxt;
    logic [DIV_WIDTH-1:0] pend_div;
    logic                 pend_vld;
    logic [DIV_WIDTH-1:0] div_nxt;

    // run_q remembers that the previous cycle was enabled, so the first
    // enabled cycle always restarts at cnt=0 with a full high phase.
    logic                 run_q;

    // Output-shaping flops: pos_q is the posedge phase, neg_q its
    // half-cycle delayed copy, odd_q the odd/even select aligned to pos_q.
    logic                 pos_q;
    logic                 neg_q;
    logic                 odd_q;

    // One extra bit so ceil(N/2) cannot overflow for N = 2^DIV_WIDTH-1.
    logic [DIV_WIDTH:0]   half_nxt;
    logic                 pos_nxt;
    logic                 tick_nxt;

    logic                 load_ok;
    logic                 load_bad;
    logic                 wrap;
    logic                 idle;
    logic                 apply;

    assign load_ok  = div_load && (div_in >= TWO);
    assign load_bad = div_load && (div_in < TWO);

    // Last cycle of a running period; the next edge starts a new period.
    assign wrap     = run_q && (cnt == div_active - ONE);

    // Not running (now or at the coming edge): no period to corrupt.
    assign idle     = !en || !run_q;

    // A pending divisor is applied only where clk_odd is at a period boundary
    // or held low, so the output cannot produce a runt pulse. The pending value
    // seen here is the old one, so a load on the same edge waits a period.
    assign apply    = pend_vld && (wrap || idle);

    assign div_nxt  = apply ? pend_div : div_active;

    // Next phase count: advance while running, restart at 0 on wrap or start.
    always_comb begin
        cnt_nxt = '0;
        if (en && run_q && !wrap) begin
            cnt_nxt = cnt + ONE;
        end
    end

    // High-phase length and per-cycle outputs for the cycle about to start,
    // using the divisor that will be in force during that cycle.
    always_comb begin
        half_nxt = ({1'b0, div_nxt} + ONE_W) >> 1;
        pos_nxt  = en && ({1'b0, cnt_nxt} < half_nxt);
        tick_nxt = en && (cnt_nxt == '0);
    end

    // Posedge state: counter, phase flop, divisor handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            run_q      <= 1'b0;
            pos_q      <= 1'b0;
            odd_q      <= DEF_DIV[0];
            tick       <= 1'b0;
            div_active <= DEF_DIV;
            pend_div   <= DEF_DIV;
            pend_vld   <= 1'b0;
            div_ack    <= 1'b0;
            div_err    <= 1'b0;
        end else begin
            cnt        <= cnt_nxt;
            run_q      <= en;
            pos_q      <= pos_nxt;
            odd_q      <= div_nxt[0];
            tick       <= tick_nxt;
            div_active <= div_nxt;
            div_ack    <= apply;
            div_err    <= load_bad;
            if (load_ok) begin
                pend_div <= div_in;
                pend_vld <= 1'b1;
            end else if (apply) begin
                pend_vld <= 1'b0;
            end
        end
    end

    // Half-cycle delayed phase; its AND with pos_q trims the leading half
    // period so odd divisors still get 50% duty.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // Output is built only from flops; no input reaches clk_odd directly.
    always_comb begin
        clk_odd = odd_q ? (pos_q & neg_q) : pos_q;
    end

endmodule

// File: tb/tb_odd_clk_divider.sv
// tb/tb_odd_clk_divider.sv - directed self-checking bench for odd_clk_divider
module tb_odd_clk_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       div_ack;
    logic       div_err;
    logic [7:0] div_active;
    logic       tick;
    logic       clk_odd;

    int n_cmp = 0;
    int n_bad = 0;

    odd_clk_divider #(.DIV_WIDTH(8), .DEFAULT_DIV(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_in     (div_in),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .div_err    (div_err),
        .div_active (div_active),
        .tick       (tick),
        .clk_odd    (clk_odd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Advance until tick is seen; ncyc = cycles advanced.
    task automatic wait_tick(input string tag, output int ncyc);
        bit found;
        found = 0;
        ncyc  = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            ncyc++;
            if (tick) found = 1;
        end
        if (!found) chk({tag, "_tick_timeout"}, 0, 1);
    endtask

    task automatic wait_ack(input string tag, output int ncyc);
        bit found;
        found = 0;
        ncyc  = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            cyc();
            ncyc++;
            if (div_ack) found = 1;
        end
        if (!found) chk({tag, "_ack_timeout"}, 0, 1);
    endtask

    // From cycle 0 of a period, sample both halves of n cycles.
    task automatic measure(input int n, output int hi, output int ticks, output int acks);
        hi = 0; ticks = 0; acks = 0;
        for (int i = 0; i < n; i++) begin
            hi    += int'(clk_odd);
            ticks += int'(tick);
            acks  += int'(div_ack);
            @(negedge clk);
            #1;
            hi += int'(clk_odd);
            cyc();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        int n, hi, tk, ak, errs;

        rst_n = 1'b0; en = 1'b0; div_in = 8'd0; div_load = 1'b0;
        cyc(); cyc();

        // 1: reset state, then default divisor 5
        chk("rst_clk_odd", clk_odd, 0);
        chk("rst_tick", tick, 0);
        chk("rst_ack", div_ack, 0);
        chk("rst_err", div_err, 0);
        chk("rst_div", div_active, 5);
        rst_n = 1'b1; en = 1'b1;
        wait_tick("t1", n);
        chk("t1_first_tick", n, 1);
        measure(5, hi, tk, ak);
        chk("t1_hi_halves", hi, 5);
        chk("t1_ticks", tk, 1);
        chk("t1_period", tick, 1);
        measure(5, hi, tk, ak);
        chk("t1_hi_halves2", hi, 5);
        chk("t1_period2", tick, 1);

        // 3: illegal divisors rejected
        div_in = 8'd1; div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        chk("t3_err1", div_err, 1);
        chk("t3_ack1", div_ack, 0);
        cyc();
        chk("t3_err1_clr", div_err, 0);
        div_in = 8'd0; div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        chk("t3_err0", div_err, 1);
        cyc();
        chk("t3_err0_clr", div_err, 0);
        ak = 0; errs = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            ak += int'(div_ack);
            errs += int'(div_err);
        end
        chk("t3_no_ack", ak, 0);
        chk("t3_no_err", errs, 0);
        chk("t3_div", div_active, 5);

        // 2: mid-period load of 4
        wait_tick("t2", n);
        cyc(); cyc();
        div_in = 8'd4; div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        chk("t2_ack_early", div_ack, 0);
        chk("t2_div_early", div_active, 5);
        wait_ack("t2", n);
        chk("t2_ack_delay", n, 2);
        chk("t2_ack_tick", tick, 1);
        chk("t2_div", div_active, 4);
        measure(4, hi, tk, ak);
        chk("t2_hi_halves", hi, 4);
        chk("t2_ticks", tk, 1);
        chk("t2_acks", ak, 1);
        chk("t2_period", tick, 1);
        measure(4, hi, tk, ak);
        chk("t2_hi_halves2", hi, 4);

        // 4: load 7 then 9 before wrap -> one ack, 9 wins
        div_in = 8'd7; div_load = 1'b1;
        cyc();
        div_in = 8'd9;
        cyc();
        div_load = 1'b0;
        chk("t4_ack_early", div_ack, 0);
        wait_ack("t4", n);
        chk("t4_ack_delay", n, 2);
        chk("t4_div", div_active, 9);
        measure(9, hi, tk, ak);
        chk("t4_hi_halves", hi, 9);
        chk("t4_ticks", tk, 1);
        chk("t4_acks", ak, 1);
        chk("t4_period", tick, 1);

        // 5: disable during high phase, idle reload, re-enable
        cyc();
        chk("t5_high", clk_odd, 1);
        en = 1'b0;
        cyc();
        chk("t5_off_clk", clk_odd, 0);
        chk("t5_off_tick", tick, 0);
        measure(5, hi, tk, ak);
        chk("t5_idle_hi", hi, 0);
        chk("t5_idle_ticks", tk, 0);
        div_in = 8'd3; div_load = 1'b1;
        cyc();
        div_load = 1'b0;
        chk("t5_idle_ack_early", div_ack, 0);
        cyc();
        chk("t5_idle_ack", div_ack, 1);
        chk("t5_idle_div", div_active, 3);
        en = 1'b1;
        cyc();
        chk("t5_restart_tick", tick, 1);
        chk("t5_ack_clr", div_ack, 0);
        measure(3, hi, tk, ak);
        chk("t5_hi_halves", hi, 3);
        chk("t5_ticks", tk, 1);
        chk("t5_period", tick, 1);

        // 6: async reset mid high phase on a negedge
        @(negedge clk);
        #1;
        chk("t6_high", clk_odd, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_clk_odd", clk_odd, 0);
        chk("t6_rst_tick", tick, 0);
        chk("t6_rst_ack", div_ack, 0);
        chk("t6_rst_err", div_err, 0);
        chk("t6_rst_div", div_active, 5);
        cyc(); cyc();
        rst_n = 1'b1;
        wait_tick("t6", n);
        chk("t6_first_tick", n, 1);
        measure(5, hi, tk, ak);
        chk("t6_hi_halves", hi, 5);
        chk("t6_period", tick, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
